test_watchdog: RTL
==================

Name: test_watchdog

Overview:
Synthesizable run monitor that sits beside the DUT inside the testbench wrapper and consumes the shared clock. It replaces ad-hoc cycle-count timeout traps with one reusable block. It tracks a test run from start to done, reloads a programmable watchdog on every kick, counts cycles and errors, and reports a sticky final verdict (PASS / FAIL / TIMEOUT) that the top level polls before ending simulation.

Parameters:
TW, 16, width of the watchdog timeout value and counter
CW, 32, width of the elapsed-cycle counter
EW, 8, width of the saturating error counter

Ports:
clk  input  1  single system clock, all state on posedge
rst  input  1  asynchronous, active-high reset
start  input  1  1-cycle pulse; begins a run (ignored while RUN)
timeout_val  input  TW  watchdog reload value, sampled on start and on each kick
kick  input  1  heartbeat from DUT/bench; reloads the watchdog
done  input  1  run-complete pulse
err  input  1  1-cycle error strobe, one per error
status  output  3  0=IDLE 1=RUN 2=PASS 3=FAIL 4=TIMEOUT
finished  output  1  high in PASS/FAIL/TIMEOUT
cycles  output  CW  cycles spent in RUN
err_count  output  EW  errors recorded this run, saturating
wd_remaining  output  TW  current watchdog count

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values (async, immediate): status=IDLE, finished=0, cycles=0, err_count=0, wd_remaining=0. A reset asserted mid-RUN aborts the run with no verdict.
- States: IDLE, RUN, PASS, FAIL, TIMEOUT. All outputs are registered. status and finished are decoded from the state register.
- IDLE -> RUN on start:
  - wd_remaining<=timeout_val, cycles<=0, err_count<=0.
  - timeout_val==0 at start: go directly to TIMEOUT next cycle.
- RUN, each cycle, evaluated in this priority order:
  1. done=1 -> PASS if err_count==0 and no err this cycle, else FAIL. Any err in the same cycle is still counted.
  2. wd_remaining==1 and kick=0 -> TIMEOUT. wd_remaining<=0.
  3. kick=1 -> wd_remaining<=timeout_val. Kick wins over expiry in the same cycle.
  4. Otherwise wd_remaining decrements by 1.
- cycles increments every RUN cycle, including the exiting cycle. It wraps at 2^CW (no saturation).
- err_count increments on err in RUN only and saturates at 2^EW-1. err outside RUN is ignored.
- Terminal states (PASS/FAIL/TIMEOUT):
  - Hold all counters frozen. finished=1.
  - start -> RUN with re-initialisation as above (re-arm without reset).
  - kick, done and err are ignored.
- start while RUN is ignored. done while IDLE is ignored.
- Latency: the verdict is visible on status one cycle after the done/expiry edge.

Test Plan:
- Reset, then start with timeout_val=10, kick every 5 cycles, done at cycle 40 with no err -> status=2, finished=1, cycles=41, err_count=0.
- start with timeout_val=8, no kick -> status=4 exactly 8 cycles after start; wd_remaining=0; cycles=8.
- timeout_val=4, kick asserted in the cycle where wd_remaining==1 -> no timeout, wd_remaining reloads to 4. Stop kicking -> TIMEOUT 4 cycles later.
- Three err pulses, then done; separately, err and done in the same cycle with err_count==0 -> both cases status=3, with err_count=3 and 1 respectively.
- EW=8, hold err=1 for 300 RUN cycles -> err_count=255, no wrap. Then done -> FAIL.
- Async rst mid-RUN (cycles=20) -> outputs clear immediately without a clock edge. start after release -> fresh run with cycles from 0. Also: start with timeout_val=0 -> TIMEOUT next cycle.

Source files
------------

// File: rtl/test_watchdog.sv
// test_watchdog: run monitor for a simulation wrapper. Tracks one test run from
// start to done, reloads a programmable watchdog on every kick, counts RUN cycles
// and errors, and holds a sticky PASS / FAIL / TIMEOUT verdict until re-armed.
module test_watchdog #(
    parameter int unsigned TW = 16,
    parameter int unsigned CW = 32,
    parameter int unsigned EW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [TW-1:0] timeout_val,
    input  logic          kick,
    input  logic          done,
    input  logic          err,
    output logic [2:0]    status,
    output logic          finished,
    output logic [CW-1:0] cycles,
    output logic [EW-1:0] err_count,
    output logic [TW-1:0] wd_remaining
);

    // Encodings double as the externally visible status code.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRun     = 3'd1,
        StPass    = 3'd2,
        StFail    = 3'd3,
        StTimeout = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] wd_q, wd_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic [EW-1:0] err_q, err_d;

    logic err_sat;
    logic wd_expiring;

    assign err_sat = &err_q;
    // A count of 0 in RUN (only reachable by kicking with timeout_val==0) is
    // treated as already expired rather than letting the decrement wrap.
    assign wd_expiring = (wd_q <= TW'(1));

    // Next-state and counter updates; everything holds unless a rule fires.
    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        cycles_d = cycles_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle, StPass, StFail, StTimeout: begin
                if (start) begin
                    state_d  = (timeout_val == '0) ? StTimeout : StRun;
                    wd_d     = timeout_val;
                    cycles_d = '0;
                    err_d    = '0;
                end
            end
            StRun: begin
                cycles_d = cycles_q + CW'(1);
                if (err && !err_sat) begin
                    err_d = err_q + EW'(1);
                end
                if (done) begin
                    // Verdict must also see an error arriving in the done cycle.
                    state_d = ((err_q == '0) && !err) ? StPass : StFail;
                end else if (!kick && wd_expiring) begin
                    state_d = StTimeout;
                    wd_d    = '0;
                end else if (kick) begin
                    wd_d = timeout_val;
                end else begin
                    wd_d = wd_q - TW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            wd_q     <= '0;
            cycles_q <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            wd_q     <= wd_d;
            cycles_q <= cycles_d;
            err_q    <= err_d;
        end
    end

    // Outputs decoded straight from registered state.
    always_comb begin
        status       = state_q;
        finished     = (state_q == StPass) || (state_q == StFail) || (state_q == StTimeout);
        cycles       = cycles_q;
        err_count    = err_q;
        wd_remaining = wd_q;
    end

endmodule
